// File: rtl/tetris_pkg.sv
// Shared Tetris playfield geometry, FSM state codes and cell addressing helper.
package tetris_pkg;

    localparam int BOARD_ROWS  = 20;
    localparam int BOARD_COLS  = 10;
    localparam int BOARD_CELLS = 200;
    localparam int COLOR_W     = 3;
    localparam int CELL_ADDR_W = 8;

    localparam logic [0:0] ST_IDLE    = 1'b0;
    localparam logic [0:0] ST_COMPACT = 1'b1;

    typedef logic [COLOR_W-1:0] color_t;

    function automatic logic [CELL_ADDR_W-1:0] cell_idx(
        input logic [4:0] row,
        input logic [3:0] col
    );
        return CELL_ADDR_W'(row) * CELL_ADDR_W'(BOARD_COLS)
             + CELL_ADDR_W'(col);
    endfunction

endpackage

// File: rtl/tetris_color_board_if.sv
// Game-FSM to color-board request bus: piece-lock and row-clear handshakes.
interface tetris_color_board_if
    import tetris_pkg::*;
();

    logic                   lock_valid;
    logic                   lock_ready;
    logic [CELL_ADDR_W-1:0] lock_pos0;
    logic [CELL_ADDR_W-1:0] lock_pos1;
    logic [CELL_ADDR_W-1:0] lock_pos2;
    logic [CELL_ADDR_W-1:0] lock_pos3;
    logic [COLOR_W-1:0]     lock_color;
    logic                   clr_valid;
    logic                   clr_ready;
    logic [BOARD_ROWS-1:0]  clr_mask;

    modport master (
        output lock_valid, lock_pos0, lock_pos1, lock_pos2, lock_pos3,
        output lock_color, clr_valid, clr_mask,
        input  lock_ready, clr_ready
    );

    modport slave (
        input  lock_valid, lock_pos0, lock_pos1, lock_pos2, lock_pos3,
        input  lock_color, clr_valid, clr_mask,
        output lock_ready, clr_ready
    );

endinterface

// File: rtl/tetris_popcount20.sv
// Combinational population count of a 20-bit row mask.
module tetris_popcount20 (
    input  logic [19:0] in_bits,
    output logic [4:0]  count
);

    always_comb begin
        count = '0;
        for (int i = 0; i < 20; i++) begin
            count = count + 5'(in_bits[i]);
        end
    end

endmodule

// File: rtl/tetris_color_board.sv
// 20x10 color playfield with piece lock, row-clear compaction and VGA read port.
// Optional TETRIS_BOARD_RD_BYPASS_EN forwards same-cycle lock colors to rd_data.
module tetris_color_board
    import tetris_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    tetris_color_board_if.slave    bus,
    input  logic                   wipe,
    input  logic [CELL_ADDR_W-1:0] rd_addr,
    output logic [COLOR_W-1:0]     rd_data,
    output logic [BOARD_CELLS-1:0] blocks_exist,
    output logic [BOARD_ROWS-1:0]  full_rows,
    output logic                   busy,
    output logic                   clr_done,
    output logic [4:0]             lines_cleared
);

    color_t                 cell_q [BOARD_CELLS];
    color_t                 cell_d [BOARD_CELLS];
    logic [0:0]             state_q, state_d;
    logic [BOARD_ROWS-1:0]  mask_q, mask_d;
    logic [5:0]             src_q, src_d;
    logic [4:0]             dst_q, dst_d;
    logic [4:0]             lines_q, lines_d;
    logic                   clr_done_q, clr_done_d;
    color_t                 rd_data_q, rd_data_d;
    logic [4:0]             mask_cnt;
    logic [CELL_ADDR_W-1:0] lock_pos [4];
    logic                   idle;
    logic                   lock_fire;
    logic                   clr_fire;
    logic                   src_vld;
    logic                   rd_hit;

    assign lock_pos[0] = bus.lock_pos0;
    assign lock_pos[1] = bus.lock_pos1;
    assign lock_pos[2] = bus.lock_pos2;
    assign lock_pos[3] = bus.lock_pos3;

    assign idle          = (state_q == ST_IDLE);
    assign bus.lock_ready = idle & ~wipe;
    assign bus.clr_ready  = idle & ~wipe & ~bus.lock_valid;
    assign lock_fire     = bus.lock_valid & bus.lock_ready;
    assign clr_fire      = bus.clr_valid & bus.clr_ready;
    // src walks below row 0 into negative values; bit 5 marks that
    assign src_vld       = ~src_q[5];

    tetris_popcount20 u_popcount (
        .in_bits (bus.clr_mask),
        .count   (mask_cnt)
    );

    always_comb begin
        cell_d     = cell_q;
        state_d    = state_q;
        mask_d     = mask_q;
        src_d      = src_q;
        dst_d      = dst_q;
        lines_d    = lines_q;
        clr_done_d = 1'b0;
        if (wipe) begin
            for (int i = 0; i < BOARD_CELLS; i++) begin
                cell_d[i] = '0;
            end
            state_d = ST_IDLE;
        end else if (idle) begin
            if (lock_fire) begin
                for (int k = 0; k < 4; k++) begin
                    if (lock_pos[k] < CELL_ADDR_W'(BOARD_CELLS)) begin
                        cell_d[lock_pos[k]] = bus.lock_color;
                    end
                end
            end else if (clr_fire) begin
                mask_d  = bus.clr_mask;
                lines_d = mask_cnt;
                src_d   = 6'd19;
                dst_d   = 5'd19;
                if (bus.clr_mask == '0) begin
                    clr_done_d = 1'b1;
                end else begin
                    state_d = ST_COMPACT;
                end
            end
        end else begin
            if (src_vld && mask_q[src_q[4:0]]) begin
                src_d = src_q - 6'd1;
            end else begin
                for (int c = 0; c < BOARD_COLS; c++) begin
                    cell_d[cell_idx(dst_q, 4'(c))] = src_vld ?
                        cell_q[cell_idx(src_q[4:0], 4'(c))] : '0;
                end
                src_d = src_q - 6'd1;
                if (dst_q == 5'd0) begin
                    state_d    = ST_IDLE;
                    clr_done_d = 1'b1;
                end else begin
                    dst_d = dst_q - 5'd1;
                end
            end
        end
    end

`ifdef TETRIS_BOARD_RD_BYPASS_EN
    always_comb begin
        rd_hit = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (lock_fire && lock_pos[k] == rd_addr) begin
                rd_hit = 1'b1;
            end
        end
    end
`else
    assign rd_hit = 1'b0;
`endif

    always_comb begin
        rd_data_d = '0;
        if (rd_addr < CELL_ADDR_W'(BOARD_CELLS)) begin
            rd_data_d = rd_hit ? bus.lock_color : cell_q[rd_addr];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < BOARD_CELLS; i++) begin
                cell_q[i] <= '0;
            end
            state_q    <= ST_IDLE;
            mask_q     <= '0;
            src_q      <= '0;
            dst_q      <= '0;
            lines_q    <= '0;
            clr_done_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            cell_q     <= cell_d;
            state_q    <= state_d;
            mask_q     <= mask_d;
            src_q      <= src_d;
            dst_q      <= dst_d;
            lines_q    <= lines_d;
            clr_done_q <= clr_done_d;
            rd_data_q  <= rd_data_d;
        end
    end

    always_comb begin
        for (int i = 0; i < BOARD_CELLS; i++) begin
            blocks_exist[i] = |cell_q[i];
        end
    end

    always_comb begin
        for (int r = 0; r < BOARD_ROWS; r++) begin
            full_rows[r] = &blocks_exist[r*BOARD_COLS +: BOARD_COLS];
        end
    end

    assign rd_data       = rd_data_q;
    assign busy          = (state_q == ST_COMPACT);
    assign clr_done      = clr_done_q;
    assign lines_cleared = lines_q;

endmodule
